// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch sequencer: FSM state encoding and BCD digit type.
package stopwatch_pkg;

   typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSE} sw_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned BCD_DIGIT_W = 4;

endpackage

// File: rtl/key_debouncer.sv
// Raw board key -> 2-flop synchroniser -> debounced "pressed" level plus a 1-cycle press pulse.
// Release transitions update the level but never produce a pulse.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic pressed,
   output logic press_pulse
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_norm;
   logic             sync0;
   logic             sync1;
   logic             pressed_d;
   logic [CNT_W-1:0] cnt;

   assign key_norm = ACTIVE_LOW ? ~key_raw : key_raw;

   // The counter runs only while the synchronised sample disagrees with the
   // accepted level; any agreeing sample (a glitch ending) restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0       <= 1'b0;
         sync1       <= 1'b0;
         pressed     <= 1'b0;
         pressed_d   <= 1'b0;
         cnt         <= '0;
         press_pulse <= 1'b0;
      end else begin
         // NOTE: non-blocking keeps sync0 -> sync1 a genuine two-stage chain;
         // blocking would collapse it into a single flop.
         sync0       <= key_norm;
         sync1       <= sync0;
         pressed_d   <= pressed;
         press_pulse <= pressed & ~pressed_d;
         if (sync1 == pressed) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            pressed <= sync1;
            cnt     <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: key debouncing, IDLE/RUN/PAUSE FSM, tick gating, counter clear and
// optional lap freeze of the displayed digits (enabled by defining STOPWATCH_LAP_EN).
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned BCD_NUM         = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 key_start_stop,
   input  logic                 key_clear,
   input  logic                 key_lap,
   input  logic [4*BCD_NUM-1:0] bcds_in,
   output logic                 incr,
   output logic                 reset_counter,
   output logic [4*BCD_NUM-1:0] bcds_out,
   output logic                 running,
   output logic                 lap_active
);

   sw_state_t state;
   logic      ss_pulse;
   logic      clr_pulse;
   logic      ss_held_unused;
   logic      clr_held_unused;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(KEY_ACTIVE_LOW)) u_deb_ss (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_start_stop),
      .pressed     (ss_held_unused),
      .press_pulse (ss_pulse)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(KEY_ACTIVE_LOW)) u_deb_clr (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_clear),
      .pressed     (clr_held_unused),
      .press_pulse (clr_pulse)
   );

`ifdef STOPWATCH_LAP_EN
   logic                        lap_pulse;
   logic                        lap_held_unused;
   bcd_digit_t [BCD_NUM-1:0]    snapshot;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(KEY_ACTIVE_LOW)) u_deb_lap (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_lap),
      .pressed     (lap_held_unused),
      .press_pulse (lap_pulse)
   );

   // NOTE: snapshot is plain data with no reset; lap_active (which is reset)
   // decides whether it is ever visible.
   always_ff @(posedge clk) begin
      if (lap_pulse && !lap_active && state == SW_RUN) begin
         snapshot <= bcds_in;
      end
   end

   assign bcds_out = lap_active ? snapshot : bcds_in;
`else
   logic lap_key_unused;

   assign lap_key_unused = key_lap;
   assign lap_active     = 1'b0;
   assign bcds_out       = bcds_in;
`endif

   // clr is evaluated ahead of ss so it wins in IDLE and PAUSE; RUN never looks at clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= SW_IDLE;
         reset_counter <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_active    <= 1'b0;
`endif
      end else begin
         reset_counter <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         if (lap_pulse) begin
            if (lap_active) begin
               lap_active <= 1'b0;
            end else if (state == SW_RUN) begin
               lap_active <= 1'b1;
            end
         end
`endif
         case (state)
            SW_IDLE: begin
               if (clr_pulse) begin
                  reset_counter <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                  lap_active    <= 1'b0;
`endif
               end else if (ss_pulse) begin
                  state <= SW_RUN;
               end
            end
            SW_RUN: begin
               if (ss_pulse) begin
                  state <= SW_PAUSE;
               end
            end
            SW_PAUSE: begin
               if (clr_pulse) begin
                  state         <= SW_IDLE;
                  reset_counter <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                  lap_active    <= 1'b0;
`endif
               end else if (ss_pulse) begin
                  state <= SW_RUN;
               end
            end
            default: state <= SW_IDLE;
         endcase
      end
   end

   // A tick coinciding with a state-changing press is judged by the pre-edge state.
   assign running = (state == SW_RUN);
   assign incr    = tick & running;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DEBOUNCE_CYCLES=4, BCD_NUM=8, tick every 10 cycles);
// exercises the lap feature when STOPWATCH_LAP_EN is defined, otherwise checks the lap key is inert.
module tb_stopwatch_ctrl;

   localparam int BCD_NUM = 8;
   localparam int DEB     = 4;
   localparam int HOLD    = 12;
   localparam int NSTEPS  = 11;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 tick_in;
   logic                 auto_tick;
   logic                 man_tick;
   logic                 auto_en;
   logic                 key_ss;
   logic                 key_clr;
   logic                 key_lap;
   logic [4*BCD_NUM-1:0] bcds_in;
   logic [4*BCD_NUM-1:0] bcds_out;
   logic                 incr;
   logic                 reset_counter;
   logic                 running;
   logic                 lap_active;

   int n_checks    = 0;
   int n_fail      = 0;
   int rc_count    = 0;
   int rc_in_reset = 0;

   typedef struct {
      logic ss;
      logic clr;
      logic lap;
      logic exp_running;
      int   exp_rc;
      logic exp_lap;
   } step_t;

   step_t steps [NSTEPS];
   step_t exp_q [$];

   always #5 clk = ~clk;

   assign tick_in = auto_tick | man_tick;

   stopwatch_ctrl #(
      .BCD_NUM         (BCD_NUM),
      .DEBOUNCE_CYCLES (DEB),
      .KEY_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick_in),
      .key_start_stop (key_ss),
      .key_clear      (key_clr),
      .key_lap        (key_lap),
      .bcds_in        (bcds_in),
      .incr           (incr),
      .reset_counter  (reset_counter),
      .bcds_out       (bcds_out),
      .running        (running),
      .lap_active     (lap_active)
   );

   initial begin
      auto_tick = 1'b0;
      forever begin
         repeat (9) @(posedge clk);
         #1 auto_tick = auto_en;
         @(posedge clk);
         #1 auto_tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (reset_counter === 1'b1) begin
         rc_count++;
         if (reset === 1'b1) rc_in_reset++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic ss, input logic clr, input logic lap);
      @(posedge clk);
      #1;
      key_ss  = ~ss;
      key_clr = ~clr;
      key_lap = ~lap;
      repeat (HOLD) @(posedge clk);
      #1;
      key_ss  = 1'b1;
      key_clr = 1'b1;
      key_lap = 1'b1;
      repeat (HOLD) @(posedge clk);
      #1;
   endtask

   task automatic run_window(input int n, input logic exp_run, input string name);
      int ticks;
      int incs;
      ticks = 0;
      incs  = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (tick_in) ticks++;
         if (incr) incs++;
      end
      check({name, " tick count"}, ticks, 2);
      check({name, " incr count"}, incs, exp_run ? ticks : 0);
   endtask

   // Press start/stop with a tick driven exactly in the cycle the press pulse is live.
   task automatic press_exact(input logic exp_inc, input logic run_before, input logic run_after,
                              input string name);
      @(posedge clk);
      #1 key_ss = 1'b0;
      repeat (DEB + 3) @(posedge clk);
      #1 man_tick = 1'b1;
      check({name, " running before"}, running, run_before);
      @(negedge clk);
      check({name, " incr on press"}, incr, exp_inc);
      @(posedge clk);
      #1 man_tick = 1'b0;
      check({name, " running after"}, running, run_after);
      key_ss = 1'b1;
      repeat (HOLD) @(posedge clk);
      #1;
   endtask

   initial begin
      // {ss, clr, lap, exp_running, exp_rc, exp_lap}
      steps[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
      steps[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0};
      steps[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
      steps[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
      steps[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
      steps[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0};
      steps[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
      steps[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      steps[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
      steps[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
      steps[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};

      reset    = 1'b1;
      key_ss   = 1'b1;
      key_clr  = 1'b1;
      key_lap  = 1'b1;
      man_tick = 1'b1;
      auto_en  = 1'b1;
      bcds_in  = 32'h1234_5678;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset running", running, 1'b0);
      check("reset incr", incr, 1'b0);
      check("reset reset_counter", reset_counter, 1'b0);
      check("reset lap_active", lap_active, 1'b0);
      check("reset bcds_out", bcds_out, 32'h1234_5678);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      man_tick = 1'b0;

      // 2-cycle glitch must not be accepted
      @(posedge clk);
      #1 key_ss = 1'b0;
      repeat (2) @(posedge clk);
      #1 key_ss = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("glitch running", running, 1'b0);
      check("glitch reset_counter count", rc_count, 0);

      for (int i = 0; i < NSTEPS; i++) begin
         int    rc0;
         step_t e;
         rc0 = rc_count;
         exp_q.push_back(steps[i]);
         press(steps[i].ss, steps[i].clr, steps[i].lap);
         e = exp_q.pop_front();
         check($sformatf("step%0d running", i), running, e.exp_running);
         check($sformatf("step%0d reset_counter cycles", i), rc_count - rc0, e.exp_rc);
         check($sformatf("step%0d lap_active", i), lap_active, e.exp_lap);
         run_window(20, e.exp_running, $sformatf("step%0d", i));
      end

      // tick coincident with press edges
      auto_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      press(1'b1, 1'b0, 1'b0);
      check("pre-exact running", running, 1'b1);
      press_exact(1'b1, 1'b1, 1'b0, "run->pause");
      press_exact(1'b0, 1'b0, 1'b1, "pause->run");
      auto_en = 1'b1;

`ifdef STOPWATCH_LAP_EN
      bcds_in = 32'h0000_0042;
      press(1'b0, 1'b0, 1'b1);
      check("lap hold active", lap_active, 1'b1);
      check("lap hold value", bcds_out, 32'h0000_0042);
      bcds_in = 32'h0000_0045;
      @(negedge clk);
      check("lap frozen while live advances", bcds_out, 32'h0000_0042);
      check("lap counting continues", running, 1'b1);

      @(posedge clk);
      #1 key_lap = 1'b0;
      repeat (DEB + 3) @(posedge clk);
      #1;
      check("lap release pulse cycle", lap_active, 1'b1);
      @(posedge clk);
      #1;
      check("lap released", lap_active, 1'b0);
      check("lap released bcds_out", bcds_out, 32'h0000_0045);
      key_lap = 1'b1;
      repeat (HOLD) @(posedge clk);
      #1;

      press(1'b0, 1'b0, 1'b1);
      check("lap re-hold", lap_active, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      check("lap kept in pause", lap_active, 1'b1);
      check("paused", running, 1'b0);
      bcds_in = 32'h0000_0050;
      press(1'b0, 1'b1, 1'b0);
      check("clear drops lap", lap_active, 1'b0);
      check("clear bcds_out live", bcds_out, 32'h0000_0050);
      press(1'b0, 1'b0, 1'b1);
      check("lap ignored in idle", lap_active, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      check("lap before reset", lap_active, 1'b1);
`else
      press(1'b0, 1'b0, 1'b1);
      check("lap key inert lap_active", lap_active, 1'b0);
      check("lap key inert running", running, 1'b1);
      bcds_in = 32'h0000_0099;
      @(negedge clk);
      check("lap key inert bcds_out", bcds_out, 32'h0000_0099);
`endif

      // reset while running
      check("running before reset", running, 1'b1);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      man_tick = 1'b1;
      auto_en  = 1'b0;
      @(posedge clk);
      #1;
      check("mid reset running", running, 1'b0);
      check("mid reset lap_active", lap_active, 1'b0);
      check("mid reset incr", incr, 1'b0);
      check("mid reset bcds_out", bcds_out, bcds_in);
      reset    = 1'b0;
      man_tick = 1'b0;
      check("reset_counter during reset", rc_in_reset, 0);
      press(1'b1, 1'b0, 1'b0);
      check("run after reset", running, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
